// File: rtl/mem_arbiter_if.sv
// Bus bundle for mem_arbiter: requester handshake on one side, memory port on the other.
// slave = arbiter view; master = client/memory view.
interface mem_arbiter_if #(
  parameter int N_REQ = 2,
  parameter int AW    = 8,
  parameter int DW    = 8
);
  logic [N_REQ-1:0]    req;
  logic [N_REQ-1:0]    req_w;
  logic [AW*N_REQ-1:0] req_addr;
  logic [DW*N_REQ-1:0] req_wdata;
  logic [N_REQ-1:0]    gnt;
  logic [N_REQ-1:0]    ack;
  logic [DW-1:0]       rdata;
  logic                busy;
  logic [AW-1:0]       mem_addr;
  logic                mem_w;
  logic [DW-1:0]       mem_wdata;
  logic [DW-1:0]       mem_rdata;

  modport slave (
    input  req, req_w, req_addr, req_wdata, mem_rdata,
    output gnt, ack, rdata, busy, mem_addr, mem_w, mem_wdata
  );

  modport master (
    output req, req_w, req_addr, req_wdata, mem_rdata,
    input  gnt, ack, rdata, busy, mem_addr, mem_w, mem_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Serialises N_REQ requesters onto one synchronous single-port memory (IDLE -> ACCESS -> ACK).
// Define MEM_ARB_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.
module mem_arbiter #(
  parameter int N_REQ = 2,
  parameter int AW    = 8,
  parameter int DW    = 8
) (
  input logic          clk,
  input logic          rst_n,
  mem_arbiter_if.slave bus
);
  localparam int IW = (N_REQ > 2) ? 2 : 1;

  typedef enum logic [1:0] {IDLE, ACCESS, ACK} state_t;

  state_t           state_q, state_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [N_REQ-1:0] ack_q, ack_d;
  logic [IW-1:0]    sel_q, sel_d;
  logic [IW-1:0]    last_q, last_d;
  logic             wr_q, wr_d;
  logic             busy_q, busy_d;
  logic [AW-1:0]    mem_addr_q, mem_addr_d;
  logic             mem_w_q, mem_w_d;
  logic [DW-1:0]    mem_wdata_q, mem_wdata_d;
  logic [DW-1:0]    rdata_q, rdata_d;

  logic             win_vld;
  logic [IW-1:0]    win;

  always_comb begin
    int unsigned idx;
    win_vld = 1'b0;
    win     = '0;
    idx     = 0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
      idx = i;
`else
      idx = (32'(last_q) + 32'd1 + i) % N_REQ;
`endif
      if (!win_vld && bus.req[IW'(idx)]) begin
        win_vld = 1'b1;
        win     = IW'(idx);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    ack_d       = '0;
    sel_d       = sel_q;
    last_d      = last_q;
    wr_d        = wr_q;
    mem_addr_d  = mem_addr_q;
    mem_w_d     = 1'b0;
    mem_wdata_d = mem_wdata_q;
    rdata_d     = rdata_q;
    unique case (state_q)
      IDLE: begin
        if (win_vld) begin
          state_d     = ACCESS;
          gnt_d       = N_REQ'(1) << win;
          sel_d       = win;
          wr_d        = bus.req_w[win];
          mem_w_d     = bus.req_w[win];
          mem_addr_d  = bus.req_addr[AW*win +: AW];
          mem_wdata_d = bus.req_wdata[DW*win +: DW];
        end
      end
      ACCESS: begin
        state_d = ACK;
        ack_d   = gnt_q;
`ifndef MEM_ARB_FIXED_PRIO_EN
        last_d  = sel_q;
`endif
      end
      ACK: begin
        state_d = IDLE;
        gnt_d   = '0;
        if (!wr_q) rdata_d = bus.mem_rdata;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      gnt_q       <= '0;
      ack_q       <= '0;
      sel_q       <= '0;
      last_q      <= IW'(N_REQ - 1);
      wr_q        <= 1'b0;
      busy_q      <= 1'b0;
      mem_addr_q  <= '0;
      mem_w_q     <= 1'b0;
      mem_wdata_q <= '0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      ack_q       <= ack_d;
      sel_q       <= sel_d;
      last_q      <= last_d;
      wr_q        <= wr_d;
      busy_q      <= busy_d;
      mem_addr_q  <= mem_addr_d;
      mem_w_q     <= mem_w_d;
      mem_wdata_q <= mem_wdata_d;
      rdata_q     <= rdata_d;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.ack       = ack_q;
  assign bus.busy      = busy_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_w     = mem_w_q;
  assign bus.mem_wdata = mem_wdata_q;
  // Memory output is only valid during ACK, so read data bypasses the register in that
  // cycle; rdata_q captures it at the end of ACK and holds it until the next read.
  assign bus.rdata = (state_q == ACK && !wr_q) ? bus.mem_rdata : rdata_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Randomised bench for mem_arbiter: N_REQ=2 and N_REQ=4 instances share stimulus and are
// compared each cycle against a timeline-based reference model.
module tb_mem_arbiter;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [3:0]  s_req, s_w;
  logic [31:0] s_addr, s_wdata;

  mem_arbiter_if #(.N_REQ(2), .AW(8), .DW(8)) b2 ();
  mem_arbiter_if #(.N_REQ(4), .AW(8), .DW(8)) b4 ();

  assign b2.req       = s_req[1:0];
  assign b2.req_w     = s_w[1:0];
  assign b2.req_addr  = s_addr[15:0];
  assign b2.req_wdata = s_wdata[15:0];
  assign b4.req       = s_req;
  assign b4.req_w     = s_w;
  assign b4.req_addr  = s_addr;
  assign b4.req_wdata = s_wdata;

  mem_arbiter #(.N_REQ(2), .AW(8), .DW(8)) u_dut2 (.clk(clk), .rst_n(rst_n), .bus(b2.slave));
  mem_arbiter #(.N_REQ(4), .AW(8), .DW(8)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(b4.slave));

  logic [7:0] ram2 [256] = '{default: 8'h00};
  logic [7:0] ram4 [256] = '{default: 8'h00};

  always @(posedge clk) begin
    if (b2.mem_w) ram2[b2.mem_addr] <= b2.mem_wdata;
    b2.mem_rdata <= ram2[b2.mem_addr];
  end

  always @(posedge clk) begin
    if (b4.mem_w) ram4[b4.mem_addr] <= b4.mem_wdata;
    b4.mem_rdata <= ram4[b4.mem_addr];
  end

  int n_chk, n_fail, cyc;

  // Reference model: index 0 models the 2-requester instance, 1 the 4-requester one.
  bit       m_act   [2];
  int       m_start [2];
  int       m_k     [2];
  int       m_last  [2];
  bit       m_w     [2];
  bit [7:0] m_addr  [2];
  bit [7:0] m_data  [2];
  bit [7:0] m_hold  [2];
  bit [7:0] m_mem   [2][256];
  bit [3:0] e_gnt   [2];
  bit [3:0] e_ack   [2];
  bit       e_busy  [2];
  bit       e_mw    [2];
  bit       e_acc   [2];
  bit [7:0] e_rd    [2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d, t=%0t)", tag, got, exp, cyc, $time);
    end
  endtask

  task automatic model_reset();
    for (int j = 0; j < 2; j++) begin
      m_act[j]  = 1'b0;
      m_last[j] = (j == 0) ? 1 : 3;
      m_hold[j] = 8'h00;
      e_gnt[j]  = '0;
      e_ack[j]  = '0;
      e_busy[j] = 1'b0;
      e_mw[j]   = 1'b0;
      e_acc[j]  = 1'b0;
      e_rd[j]   = 8'h00;
    end
  endtask

  // An access picked in cycle S owns the memory in S+1 (access) and S+2 (ack);
  // the arbiter can pick again in S+3.
  task automatic model_step(input int j);
    int  n = (j == 0) ? 2 : 4;
    int  a, idx;
    bit  found = 1'b0;
    if (!m_act[j] || cyc >= m_start[j] + 3) begin
      m_act[j] = 1'b0;
      for (int off = 0; off < n; off++) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
        idx = off;
`else
        idx = (m_last[j] + 1 + off) % n;
`endif
        if (!found && s_req[idx]) begin
          found      = 1'b1;
          m_act[j]   = 1'b1;
          m_start[j] = cyc;
          m_k[j]     = idx;
          m_w[j]     = s_w[idx];
          m_addr[j]  = s_addr[8*idx +: 8];
          m_data[j]  = s_wdata[8*idx +: 8];
`ifndef MEM_ARB_FIXED_PRIO_EN
          m_last[j]  = idx;
`endif
        end
      end
    end
    a         = m_act[j] ? (cyc + 1 - m_start[j]) : 0;
    e_acc[j]  = (a == 1);
    e_busy[j] = (a == 1) || (a == 2);
    e_gnt[j]  = e_busy[j] ? 4'(1 << m_k[j]) : 4'b0;
    e_ack[j]  = (a == 2) ? 4'(1 << m_k[j]) : 4'b0;
    e_mw[j]   = (a == 1) && m_w[j];
    if (a == 2) begin
      if (m_w[j]) m_mem[j][m_addr[j]] = m_data[j];
      else        m_hold[j] = m_mem[j][m_addr[j]];
    end
    e_rd[j] = m_hold[j];
  endtask

  task automatic check_inst(input int j, input logic [3:0] gnt, input logic [3:0] ack,
                            input logic busy, input logic mw, input logic [7:0] maddr,
                            input logic [7:0] mwd, input logic [7:0] rd);
    string s = (j == 0) ? "2" : "4";
    check({"gnt", s},   32'(gnt),  32'(e_gnt[j]));
    check({"ack", s},   32'(ack),  32'(e_ack[j]));
    check({"busy", s},  32'(busy), 32'(e_busy[j]));
    check({"mem_w", s}, 32'(mw),   32'(e_mw[j]));
    check({"rdata", s}, 32'(rd),   32'(e_rd[j]));
    if (e_acc[j]) begin
      check({"mem_addr", s}, 32'(maddr), 32'(m_addr[j]));
      if (m_w[j]) check({"mem_wdata", s}, 32'(mwd), 32'(m_data[j]));
    end
  endtask

  task automatic tick();
    if (rst_n) begin
      model_step(0);
      model_step(1);
    end else begin
      model_reset();
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
    check_inst(0, {2'b00, b2.gnt}, {2'b00, b2.ack}, b2.busy, b2.mem_w, b2.mem_addr,
               b2.mem_wdata, b2.rdata);
    check_inst(1, b4.gnt, b4.ack, b4.busy, b4.mem_w, b4.mem_addr, b4.mem_wdata, b4.rdata);
  endtask

  initial begin
    n_chk   = 0;
    n_fail  = 0;
    cyc     = 0;
    rst_n   = 1'b0;
    s_req   = 4'hF;
    s_w     = 4'h0;
    s_addr  = '0;
    s_wdata = '0;
    model_reset();

    // reset held with every request asserted
    repeat (3) tick();
    check("rst_mem_addr4", 32'(b4.mem_addr), 32'h0);

    // release: requester 0 wins first
    rst_n = 1'b1;
    tick();
    check("first_gnt2", 32'(b2.gnt), 32'h1);
    check("first_gnt4", 32'(b4.gnt), 32'h1);
    tick();
    s_req = 4'h0;
    repeat (2) tick();

    // single write then read of 0x55
    s_req = 4'b0001; s_w = 4'b0001; s_addr[7:0] = 8'h55; s_wdata[7:0] = 8'h56;
    tick();
    check("wr_mem_w", 32'(b2.mem_w), 32'h1);
    check("wr_mem_addr", 32'(b2.mem_addr), 32'h55);
    tick();
    check("wr_ack", 32'(b2.ack), 32'h1);
    check("wr_mem_w_low", 32'(b2.mem_w), 32'h0);
    s_req = 4'h0;
    tick();
    s_req = 4'b0001; s_w = 4'b0000;
    repeat (2) tick();
    check("rd_ack", 32'(b2.ack), 32'h1);
    check("rd_rdata", 32'(b2.rdata), 32'h56);
    s_req = 4'h0;
    repeat (2) tick();

    // contention: both write, held for several rounds
    s_req = 4'b0011; s_w = 4'b0011; s_addr[15:0] = 16'h2010; s_wdata[15:0] = 16'hB2A1;
    repeat (12) tick();
    s_req = 4'h0;
    repeat (2) tick();

    // reset during the access phase of a write to 0x33
    s_req = 4'b0001; s_w = 4'b0001; s_addr[7:0] = 8'h33; s_wdata[7:0] = 8'hAA;
    tick();
    check("mid_mem_w_pre", 32'(b4.mem_w), 32'h1);
    rst_n = 1'b0;
    #1;
    check("mid_mem_w2", 32'(b2.mem_w), 32'h0);
    check("mid_mem_w4", 32'(b4.mem_w), 32'h0);
    check("mid_gnt4", 32'(b4.gnt), 32'h0);
    check("mid_busy4", 32'(b4.busy), 32'h0);
    s_req = 4'h0;
    model_reset();
    repeat (2) tick();
    rst_n = 1'b1;
    tick();

    // round-robin wrap after reset: reads from requesters 0 and 3
    s_req = 4'b1001; s_w = 4'b0000; s_addr = 32'h4400_0033;
    tick();
    check("wrap_gnt4_first", 32'(b4.gnt), 32'h1);
    tick();
    check("rst_drop_rd2", 32'(b2.rdata), 32'h00);
    check("rst_drop_rd4", 32'(b4.rdata), 32'h00);
    repeat (2) tick();
    check("wrap_gnt4_next", 32'(b4.gnt), 32'h8);
    tick();
    s_req = 4'h0;
    repeat (2) tick();

    // a pending requester changes its address while another is served
    s_req = 4'b0001; s_w = 4'b0001; s_addr = 32'h0000_0040; s_wdata = 32'h0000_0011;
    tick();
    s_req = 4'b0011; s_addr[15:8] = 8'h41;
    tick();
    s_req = 4'b0010; s_addr[15:8] = 8'h99;
    tick();
    tick();
    check("late_addr2", 32'(b2.mem_addr), 32'h99);
    check("late_addr4", 32'(b4.mem_addr), 32'h99);
    tick();
    s_req = 4'h0;
    repeat (2) tick();

    // randomised traffic
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 4; i++) begin
        if (s_req[i]) begin
          if (e_ack[1][i]) begin
            if ($urandom_range(1, 0) == 0) begin
              s_req[i] = 1'b0;
            end else begin
              s_w[i]            = 1'($urandom);
              s_addr[8*i +: 8]  = 8'($urandom_range(15, 0));
              s_wdata[8*i +: 8] = 8'($urandom);
            end
          end else if (e_busy[1] && !e_gnt[1][i] && $urandom_range(7, 0) == 0) begin
            s_addr[8*i +: 8] = 8'($urandom_range(15, 0));
          end
        end else if ($urandom_range(3, 0) == 0) begin
          s_req[i]          = 1'b1;
          s_w[i]            = 1'($urandom);
          s_addr[8*i +: 8]  = 8'($urandom_range(15, 0));
          s_wdata[8*i +: 8] = 8'($urandom);
        end
      end
      tick();
    end
    s_req = 4'h0;
    repeat (4) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
